// File: rtl/ntt_unloader_pkg.sv
// Shared NTT definitions: default sizes, unloader FSM states and the
// bit-reverse helper used to undo the transform's output permutation.
package ntt_unloader_pkg;

    localparam int NTT_DATA_SIZE_ARB = 13;
    localparam int NTT_RING_SIZE     = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } unl_state_e;

    // Reverses the low w bits of a; bits above w come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] a, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = a[w-1-i];
        return r;
    endfunction

endpackage

// File: rtl/ntt_out_fifo.sv
// Two-entry output buffer; head entry drives the outputs straight from flops,
// so data and valid stay stable while the sink stalls.
module ntt_out_fifo #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
    logic         v0_q, v0_d, v1_q, v1_d;

    always_comb begin
        d0_d = d0_q;
        d1_d = d1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        if (v0_q && ready_i) begin
            d0_d = d1_q;
            v0_d = v1_q;
            v1_d = 1'b0;
        end
        // Upstream credit check guarantees a free slot after any pop.
        if (push_i) begin
            if (!v0_d) begin
                d0_d = wdata_i;
                v0_d = 1'b1;
            end else begin
                d1_d = wdata_i;
                v1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            d0_q <= '0;
            d1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign valid_o = v0_q;
    assign data_o  = d0_q;
    assign count_o = {1'b0, v0_q} + {1'b0, v1_q};

endmodule

// File: rtl/ntt_unloader.sv
// Streams a finished polynomial out of the result RAM, natural or bit-reversed
// order, with a credit-limited read pipeline feeding a 2-entry output buffer.
module ntt_unloader
    import ntt_unloader_pkg::*;
#(
    parameter int  DATA_SIZE_ARB = NTT_DATA_SIZE_ARB,
    parameter int  RING_SIZE     = NTT_RING_SIZE,
    localparam int ADDR_W        = $clog2(RING_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     bitrev_en,
    output logic                     ram_re,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [DATA_SIZE_ARB-1:0] ram_rdata,
    output logic [DATA_SIZE_ARB-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     busy,
    output logic                     done
);

    unl_state_e        state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              rev_q, rev_d;
    logic              infl_q, infl_last_q;
    logic              xfer, issue, last_rd;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;
    logic [ADDR_W-1:0] rev_addr;

    assign xfer     = dout_valid & dout_ready;
    // Slots already committed: buffered + returning next cycle - leaving now.
    assign occ      = {1'b0, fifo_cnt} + {2'b0, infl_q} - {2'b0, xfer};
    assign issue    = (state_q == READ) && (occ < 3'd2);
    assign last_rd  = (k_q == ADDR_W'(RING_SIZE - 1));
    assign rev_addr = ADDR_W'(bit_rev(32'(k_q), ADDR_W));

    assign ram_re   = issue;
    assign ram_addr = issue ? (rev_q ? rev_addr : k_q) : '0;
    assign busy     = (state_q == READ) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rev_d   = rev_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = READ;
                k_d     = '0;
                rev_d   = bitrev_en;
            end
            READ: if (issue) begin
                if (last_rd) state_d = DRAIN;
                else         k_d     = k_q + 1'b1;
            end
            DRAIN:   if (xfer && dout_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            rev_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rev_q       <= rev_d;
            infl_q      <= issue;
            infl_last_q <= issue & last_rd;
        end
    end

    ntt_out_fifo #(
        .W(DATA_SIZE_ARB + 1)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (infl_q),
        .wdata_i ({infl_last_q, ram_rdata}),
        .ready_i (dout_ready),
        .valid_o (dout_valid),
        .data_o  ({dout_last, dout}),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_ntt_unloader.sv
// Scoreboard bench for ntt_unloader with RING_SIZE=8 and RAM[i]=100+i.
module tb_ntt_unloader;

    localparam int DW = 13;
    localparam int RS = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          bitrev_en = 1'b0;
    logic          dout_ready = 1'b1;
    logic          ram_re, dout_valid, dout_last, busy, done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata, dout;

    always #5 clk = ~clk;

    ntt_unloader #(.DATA_SIZE_ARB(DW), .RING_SIZE(RS)) dut (
        .clk(clk), .reset(reset), .start(start), .bitrev_en(bitrev_en),
        .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .busy(busy), .done(done)
    );

    // RAM returns data one cycle after a read, junk otherwise.
    always @(posedge clk) ram_rdata <= ram_re ? DW'(100 + int'(ram_addr)) : DW'($urandom);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int exp_a[$], exp_d[$];
    bit exp_l[$];
    int issued = 0, xfers = 0, pass_x = 0, done_cnt = 0, start_cyc = 0;
    bit done_due = 0, hold = 0, rst_chk = 0, first_re_pend = 0, first_v_pend = 0;
    bit rand_ready = 0;
    logic [DW-1:0] prev_dout;
    logic          prev_last;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    function automatic int rev3(input int i);
        int r = 0;
        for (int b = 0; b < AW; b++) r = r * 2 + ((i >> b) & 1);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_chk) begin
            check("reset_outputs", {ram_re, ram_addr, dout, dout_valid, dout_last, busy, done}, 64'd0);
            rst_chk = 0;
        end else begin
            if (hold) begin
                check("stall_valid", dout_valid, 1);
                check("stall_stable", {dout_last, dout}, {prev_last, prev_dout});
            end
            if (done || done_due) check("done_pulse", done, done_due);
            if (done) done_cnt++;
            done_due = 0;
            if (!ram_re) check("addr_idle", ram_addr, 0);
            if (ram_re) begin
                issued++;
                if (first_re_pend) begin
                    check("re_latency", cyc - start_cyc, 0);
                    check("busy", busy, 1);
                    first_re_pend = 0;
                end
                if (exp_a.size() == 0) check("spurious_read", 1, 0);
                else check("ram_addr", ram_addr, exp_a.pop_front());
            end
            if (dout_valid && first_v_pend) begin
                check("valid_latency", cyc - start_cyc, 2);
                first_v_pend = 0;
            end
            if (dout_valid && dout_ready) begin
                xfers++;
                pass_x++;
                if (exp_d.size() == 0) check("spurious_xfer", 1, 0);
                else begin
                    check("dout", dout, exp_d.pop_front());
                    done_due = exp_l.pop_front();
                    check("dout_last", dout_last, done_due);
                end
            end
            if (ram_re) check("credit", (issued - xfers) <= 2, 1);
            hold      = dout_valid && !dout_ready;
            prev_dout = dout;
            prev_last = dout_last;
        end
        if (!reset) begin
            exp_a.delete(); exp_d.delete(); exp_l.delete();
            issued = 0; xfers = 0; done_due = 0; hold = 0;
            first_re_pend = 0; first_v_pend = 0;
            rst_chk = 1;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) dout_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic start_pass(input bit br);
        @(posedge clk); #1;
        for (int i = 0; i < RS; i++) begin
            int a = br ? rev3(i) : i;
            exp_a.push_back(a);
            exp_d.push_back(100 + a);
            exp_l.push_back(i == RS - 1);
        end
        start = 1; bitrev_en = br;
        first_re_pend = 1; first_v_pend = 1; pass_x = 0; done_cnt = 0;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 0;
        bitrev_en = $urandom_range(0, 1);
    endtask

    task automatic wait_end();
        int n = 0;
        while (done_cnt == 0 && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #1;
        check("done_seen", done_cnt, 1);
        check("xfer_count", pass_x, RS);
        check("queue_empty", exp_d.size(), 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk); #1 reset = 1;

        start_pass(0); wait_end();
        start_pass(1); wait_end();

        dout_ready = 0;
        start_pass(0);
        for (int n = 0; n < 20 && !dout_valid; n++) @(negedge clk);
        check("stall_valid_seen", dout_valid, 1);
        repeat (5) @(posedge clk);
        #1 dout_ready = 1;
        wait_end();

        start_pass(0);
        repeat (3) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
        wait_end();

        start_pass(1);
        for (int n = 0; n < 30 && pass_x < 3; n++) @(negedge clk);
        check("pre_reset_xfers", pass_x, 3);
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1 reset = 1;
        repeat (2) @(posedge clk);
        start_pass(0); wait_end();

        rand_ready = 1;
        for (int p = 0; p < 6; p++) begin
            start_pass($urandom_range(0, 1));
            wait_end();
        end
        rand_ready = 0;
        dout_ready = 1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ntt_unloader.md
NTT_UNLOADER -- requirements
Module: ntt_unloader

Interface
REQ-001 SHALL have parameter DATA_SIZE_ARB, default 13, meaning coefficient width in bits.
REQ-002 SHALL have parameter RING_SIZE, default 256, meaning number of coefficients per polynomial (power of two); ADDR_W = clog2(RING_SIZE).
REQ-003 SHALL have port clk  input  1  clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse: transform results are complete in RAM.
REQ-006 SHALL have port bitrev_en  input  1  1 = read addresses in bit-reversed order, 0 = natural order.
REQ-007 SHALL have port ram_re  output  1  result-RAM read enable.
REQ-008 SHALL have port ram_addr  output  ADDR_W  result-RAM read address.
REQ-009 SHALL have port ram_rdata  input  DATA_SIZE_ARB  RAM read data, valid exactly one cycle after ram_re.
REQ-010 SHALL have port dout  output  DATA_SIZE_ARB  streamed coefficient.
REQ-011 SHALL have port dout_valid  output  1  dout holds a coefficient.
REQ-012 SHALL have port dout_ready  input  1  sink accepts; transfer occurs when dout_valid and dout_ready are both 1.
REQ-013 SHALL have port dout_last  output  1  marks the final coefficient (index RING_SIZE-1 of the sequence).
REQ-014 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final transfer.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-017 IDLE -> READ on start; IDLE holds otherwise.
REQ-018 READ -> DRAIN in the cycle that issues read number RING_SIZE-1 (final read).
REQ-019 DRAIN -> DONE on the transfer with dout_last=1.
REQ-020 DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 bitrev_en SHALL be sampled on the accepted start and held for the whole pass.
REQ-023 Read counter k counts 0..RING_SIZE-1 and SHALL not wrap within a pass; ram_addr = k, or k bit-reversed over ADDR_W bits when bitrev_en was sampled 1.
REQ-024 ram_re SHALL assert in cycle T+1 for a start accepted at edge T, provided buffer credit exists.
REQ-025 Output buffer SHALL be 2 entries deep; dout/dout_valid/dout_last SHALL be driven from registers.
REQ-026 A read SHALL be issued only when (buffered entries + reads in flight - transfer this cycle) < 2.
REQ-027 With dout_ready held 1, first dout_valid SHALL be in cycle T+3 and throughput SHALL be one coefficient per cycle thereafter.
REQ-028 While dout_valid=1 and dout_ready=0, dout and dout_last SHALL stay stable.
REQ-029 Coefficients SHALL leave in read order; none dropped or duplicated under any dout_ready pattern.
REQ-030 dout SHALL equal ram_rdata bit-for-bit; no arithmetic is applied.
REQ-031 ram_addr SHALL be 0 and ram_re 0 whenever no read is issued.

Reset
REQ-032 With reset=0 at a rising edge: state IDLE; ram_re, ram_addr, dout, dout_valid, dout_last, busy, done all 0; buffer emptied; counter 0.
REQ-033 Reset mid-pass SHALL abort the pass, discard in-flight data, and ignore RAM data returning in the following cycle.

Structure
REQ-034 The state enum and the bit-reverse address function SHALL live in the shared NTT package alongside DATA_SIZE_ARB and RING_SIZE.
REQ-035 The 2-entry output buffer SHALL be a sub-module named ntt_out_fifo; all else stays in ntt_unloader.

Verification (RING_SIZE=8, RAM[i]=100+i)
REQ-036 start, bitrev_en=0, dout_ready=1 -> ram_addr 0..7 on consecutive cycles, dout 100..107 from T+3, dout_last with 107, done one cycle after.
REQ-037 start, bitrev_en=1 -> ram_addr 0,4,2,6,1,5,3,7; dout 100,104,102,106,101,105,103,107.
REQ-038 dout_ready=0 for 5 cycles after first dout_valid -> dout stays 100, ram_re stops after 2 outstanding, resumes on ready; full sequence intact.
REQ-039 start re-pulsed at T+4 while busy -> ignored; exactly 8 transfers, one done.
REQ-040 reset=0 at the 4th transfer -> all outputs 0 next cycle; new start gives a clean 8-coefficient pass beginning at 100.
